// File: rtl/td4_pkg.sv
// Shared constants for the TD4 front end: data width and debounce defaults.
package td4_pkg;

    // Width of the CPU input port, which is also the number of board switches.
    localparam int unsigned TD4_DATA_W = 4;

    // 10 ms of stable input at 50 MHz before a new level is accepted.
    localparam int unsigned TD4_DEBOUNCE_DEFAULT = 500000;

    // Smallest counter width that holds TD4_DEBOUNCE_DEFAULT-1.
    localparam int unsigned TD4_DEBOUNCE_CNT_W = 19;

endpackage

// File: rtl/td4_debounce_bit.sv
// One conditioned input channel: 2-flop synchronizer, saturating debounce
// counter and the accepted stable level. rise/fall flag the edge on which
// stable is about to change, so a registered consumer lines up with stable.
module td4_debounce_bit
    import td4_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = TD4_DEBOUNCE_DEFAULT,
    parameter int unsigned CNT_W           = TD4_DEBOUNCE_CNT_W
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;
    logic             mismatch;
    logic             accept;

    // Two-stage synchronizer for the asynchronous board input.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Count consecutive mismatching cycles; any match discards the count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (!mismatch) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            stable <= sync2;
            cnt    <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Strobes are valid in the cycle before stable changes.
    always_comb begin
        mismatch = (sync2 != stable);
        accept   = mismatch && (cnt == CNT_LAST);
        rise     = accept && sync2;
        fall     = accept && !sync2;
    end

endmodule

// File: rtl/td4_input_conditioner.sv
// TD4 front end: debounces the slide switches into the CPU input bus and the
// step button into a single-cycle step strobe.
module td4_input_conditioner
    import td4_pkg::*;
#(
    parameter int unsigned SW_W            = TD4_DATA_W,
    parameter int unsigned DEBOUNCE_CYCLES = TD4_DEBOUNCE_DEFAULT,
    parameter int unsigned CNT_W           = TD4_DEBOUNCE_CNT_W
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [SW_W-1:0] sw_raw,
    input  logic            btn_raw,
    output logic [SW_W-1:0] sw_out,
    output logic            sw_changed,
    output logic            step_pulse
);

    // Channel SW_W is the button; channels below it are the switches.
    logic [SW_W:0] raw_vec;
    logic [SW_W:0] stable_vec;
    logic [SW_W:0] rise_vec;
    logic [SW_W:0] fall_vec;

    assign raw_vec = {btn_raw, sw_raw};
    assign sw_out  = stable_vec[SW_W-1:0];

    for (genvar i = 0; i <= SW_W; i++) begin : g_chan
        td4_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_bit (
            .clock (clock),
            .reset (reset),
            .raw   (raw_vec[i]),
            .stable(stable_vec[i]),
            .rise  (rise_vec[i]),
            .fall  (fall_vec[i])
        );
    end

    // Register the strobes on the same edge that updates the stable levels.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sw_changed <= 1'b0;
            step_pulse <= 1'b0;
        end else begin
            sw_changed <= |(rise_vec[SW_W-1:0] | fall_vec[SW_W-1:0]);
            // rise and fall are exclusive; the mask only ties the strobe to 0->1.
            step_pulse <= rise_vec[SW_W] & ~fall_vec[SW_W];
        end
    end

endmodule

// File: tb/tb_td4_input_conditioner.sv
// Self-checking bench for td4_input_conditioner with DEBOUNCE_CYCLES=4.
module tb_td4_input_conditioner;

    localparam int N = 4;
    localparam int W = 4;

    logic         clock   = 1'b0;
    logic         reset   = 1'b0;
    logic [W-1:0] sw_raw  = '0;
    logic         btn_raw = 1'b0;
    logic [W-1:0] sw_out;
    logic         sw_changed;
    logic         step_pulse;

    always #5 clock = ~clock;

    td4_input_conditioner #(
        .SW_W           (W),
        .DEBOUNCE_CYCLES(N),
        .CNT_W          (3)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .sw_raw    (sw_raw),
        .btn_raw   (btn_raw),
        .sw_out    (sw_out),
        .sw_changed(sw_changed),
        .step_pulse(step_pulse)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a level is accepted once the synchronizer output
    // (raw delayed by two edges) has differed from it for N edges in a row.
    logic         win  [W+1][N+2];
    logic         m_st [W+1];
    logic [W-1:0] m_sw;
    logic         m_chg;
    logic         m_step;

    typedef struct {
        logic [W-1:0] sw;
        logic         btn;
        int           hold;
        logic [W-1:0] exp_sw;
        int           exp_chg;
        int           exp_step;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int ch = 0; ch <= W; ch++) begin
            for (int i = 0; i < N + 2; i++) win[ch][i] = 1'b0;
            m_st[ch] = 1'b0;
        end
        m_sw   = '0;
        m_chg  = 1'b0;
        m_step = 1'b0;
    endtask

    task automatic model_edge();
        logic raw;
        logic all_diff;
        m_chg  = 1'b0;
        m_step = 1'b0;
        if (!reset) begin
            model_reset();
        end else begin
            for (int ch = 0; ch <= W; ch++) begin
                raw = (ch < W) ? sw_raw[ch] : btn_raw;
                for (int i = N + 1; i > 0; i--) win[ch][i] = win[ch][i-1];
                win[ch][0] = raw;
                all_diff = 1'b1;
                for (int i = 2; i <= N + 1; i++)
                    if (win[ch][i] == m_st[ch]) all_diff = 1'b0;
                if (all_diff) begin
                    m_st[ch] = !m_st[ch];
                    if (ch < W) m_chg = 1'b1;
                    else if (m_st[ch]) m_step = 1'b1;
                end
            end
            for (int ch = 0; ch < W; ch++) m_sw[ch] = m_st[ch];
        end
    endtask

    // One rising edge, then compare all outputs against the model.
    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
        chk("mdl_sw_out", int'(sw_out), int'(m_sw));
        chk("mdl_sw_changed", int'(sw_changed), int'(m_chg));
        chk("mdl_step_pulse", int'(step_pulse), int'(m_step));
    endtask

    task automatic hold(input logic [W-1:0] s, input logic b, input int n,
                        output int chg, output int stp);
        sw_raw  = s;
        btn_raw = b;
        chg = 0;
        stp = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            chg += int'(sw_changed);
            stp += int'(step_pulse);
        end
    endtask

    initial begin
        int chg, stp, first, cnt, bad;

        tbl[0] = '{4'hF, 1'b0, 8, 4'hF, 1, 0};
        tbl[1] = '{4'h3, 1'b1, 8, 4'h3, 1, 1};
        tbl[2] = '{4'h3, 1'b0, 3, 4'h3, 0, 0};
        tbl[3] = '{4'h3, 1'b1, 8, 4'h3, 0, 0};
        tbl[4] = '{4'h0, 1'b0, 8, 4'h0, 1, 0};
        tbl[5] = '{4'h8, 1'b0, 5, 4'h0, 0, 0};
        tbl[6] = '{4'h8, 1'b0, 1, 4'h8, 1, 0};

        model_reset();

        // Power-up with switches already high during reset.
        sw_raw = 4'b1010;
        #1;
        chk("rst_sw_out", int'(sw_out), 0);
        chk("rst_sw_changed", int'(sw_changed), 0);
        chk("rst_step_pulse", int'(step_pulse), 0);
        tick();
        tick();
        reset = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("pwr_sw_out", int'(sw_out), (i == 6) ? 4'b1010 : 0);
            chk("pwr_sw_changed", int'(sw_changed), (i == 6) ? 1 : 0);
        end
        tick();
        chk("pwr_sw_changed_one_cycle", int'(sw_changed), 0);
        hold(4'h0, 1'b0, 8, chg, stp);

        // Table-driven segments.
        foreach (tbl[k]) begin
            hold(tbl[k].sw, tbl[k].btn, tbl[k].hold, chg, stp);
            chk($sformatf("tbl%0d_sw_out", k), int'(sw_out), int'(tbl[k].exp_sw));
            chk($sformatf("tbl%0d_chg_count", k), chg, tbl[k].exp_chg);
            chk($sformatf("tbl%0d_step_count", k), stp, tbl[k].exp_step);
        end

        // Glitch rejection: 3-cycle pulse on bit 0.
        hold(4'h0, 1'b0, 8, chg, stp);
        hold(4'h1, 1'b0, 3, chg, stp);
        cnt = chg;
        hold(4'h0, 1'b0, 10, chg, stp);
        cnt += chg;
        chk("glitch_sw_out", int'(sw_out), 0);
        chk("glitch_chg_count", cnt, 0);

        // Multi-bit change lands in one cycle with one strobe.
        hold(4'b1010, 1'b0, 8, chg, stp);
        sw_raw = 4'b0101;
        first = -1;
        cnt = 0;
        bad = 0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (first < 0 && sw_out == 4'b0101) first = e;
            if (sw_out != 4'b0101 && sw_out != 4'b1010) bad++;
            cnt += int'(sw_changed);
        end
        chk("multi_latency", first, 6);
        chk("multi_chg_count", cnt, 1);
        chk("multi_intermediate", bad, 0);

        // Button bounce then hold then release.
        hold(4'h0, 1'b0, 8, chg, stp);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            btn_raw = (i % 2 == 0);
            tick();
            cnt += int'(step_pulse);
        end
        first = -1;
        for (int e = 2; e <= 20; e++) begin
            tick();
            if (step_pulse) begin
                cnt++;
                if (first < 0) first = e;
            end
        end
        chk("btn_pulse_edge", first, 6);
        chk("btn_pulse_count", cnt, 1);
        hold(4'h0, 1'b0, 10, chg, stp);
        chk("btn_release_pulses", stp, 0);

        // Asynchronous reset in the middle of a count.
        hold(4'b0001, 1'b0, 8, chg, stp);
        chk("areset_pre_sw_out", int'(sw_out), 1);
        hold(4'b1001, 1'b0, 3, chg, stp);
        #3;
        reset = 1'b0;
        model_reset();
        #1;
        chk("areset_sw_out", int'(sw_out), 0);
        chk("areset_sw_changed", int'(sw_changed), 0);
        chk("areset_step_pulse", int'(step_pulse), 0);
        tick();
        tick();
        reset = 1'b1;
        first = -1;
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (first < 0 && sw_out == 4'b1001) first = e;
        end
        chk("areset_fresh_latency", first, 6);

        // Channel independence: bit 1 glitches while bit 2 is held high.
        hold(4'h0, 1'b0, 8, chg, stp);
        first = -1;
        bad = 0;
        for (int e = 1; e <= 12; e++) begin
            sw_raw = {1'b0, 1'b1, (e % 3 != 0), 1'b0};
            tick();
            if (first < 0 && sw_out[2]) first = e;
            if (sw_out[1]) bad++;
        end
        chk("indep_bit2_latency", first, 6);
        chk("indep_bit1_changes", bad, 0);
        hold(4'h0, 1'b0, 8, chg, stp);

        // Randomized segments against the model, with occasional async reset.
        for (int s = 0; s < 1200; s++) begin
            if ($urandom_range(0, 49) == 0) begin
                #3;
                reset = 1'b0;
                model_reset();
                #1;
                chk("rand_areset_sw_out", int'(sw_out), 0);
                tick();
                reset = 1'b1;
            end
            hold(W'($urandom), 1'($urandom), int'($urandom_range(1, 8)), chg, stp);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/td4_input_conditioner.md
Name: td4_input_conditioner

Overview:
Front-end stage that directly feeds the TD4 CPU top level. It conditions the four raw board slide switches into the clean `sw[3:0]` input-port bus the CPU reads. It also conditions one raw push button into a single-cycle `step_pulse`, used for single-step clocking of the CPU. Each input goes through a 2-flop synchronizer, then a per-channel saturating debounce counter.

Parameters:
- SW_W, 4, number of switch channels (matches the CPU input-port width).
- DEBOUNCE_CYCLES, 500000, consecutive stable clock cycles required before a new level is accepted (10 ms at 50 MHz). Legal values are ≥ 2. The bench uses 4.
- CNT_W, 19, counter width. Must satisfy 2^CNT_W ≥ DEBOUNCE_CYCLES.

Ports:
- clock  in  1  system clock; all state is updated on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- sw_raw  in  SW_W  unsynchronized board switches.
- btn_raw  in  1  unsynchronized step push button (1 = pressed).
- sw_out  out  SW_W  debounced switch levels; drives the CPU `sw` input.
- sw_changed  out  1  one-cycle strobe, high on the cycle in which any `sw_out` bit takes a new value.
- step_pulse  out  1  one-cycle strobe on each debounced press (0→1) of the button.

Behaviour:
- Reset (reset=0, asynchronous): all synchronizer flops, counters, stable levels, `sw_out`, `sw_changed` and `step_pulse` are forced to 0 immediately. This holds regardless of the clock.
- Synchronizer: `sync1 <= raw`, `sync2 <= sync1` on each channel.
- Per-channel debounce, evaluated each rising edge:
  - If `sync2 == stable`: counter <= 0.
  - Else if `counter == DEBOUNCE_CYCLES-1`: `stable <= sync2`, counter <= 0.
  - Else: counter <= counter + 1.
- Glitch rejection: any mismatch lasting fewer than DEBOUNCE_CYCLES cycles at `sync2` clears the counter and leaves `stable` unchanged. Bounce never accumulates across glitches.
- Latency: a raw level held constant is reflected on `stable` exactly DEBOUNCE_CYCLES+2 rising edges after the first edge that samples it. With DEBOUNCE_CYCLES=4 this is 6 edges.
- `sw_out` is the vector of the switch channels' `stable` registers.
- `sw_changed`:
  - Registered; asserted for exactly one cycle, coincident with the first cycle the new `sw_out` value is visible.
  - Several bits updating on the same edge produce a single one-cycle pulse.
  - Bits updating on consecutive edges produce back-to-back pulses.
- `step_pulse`:
  - Asserted for exactly one cycle when the button channel's `stable` goes 0→1, coincident with that update.
  - Never asserted on 1→0.
  - A held button gives one pulse only.
- Power-up: `stable` resets to 0. If a switch is already high at reset release, `sw_out` rises after DEBOUNCE_CYCLES+2 edges with a `sw_changed` pulse; this is intended behaviour. The same applies to a button held through reset, which produces a `step_pulse`.
- Reset mid-operation: partial counts are discarded. After release, debouncing restarts from counter=0 and stable=0.
- Counter never exceeds DEBOUNCE_CYCLES-1, so no wrap-around is possible.
- Channels are fully independent; a change on one channel never resets another channel's counter.

Decomposition:
- Shared package `td4_pkg` holds:
  - `TD4_DATA_W = 4`
  - `TD4_DEBOUNCE_DEFAULT = 500000`
  - `TD4_DEBOUNCE_CNT_W = 19`
- Sub-module `td4_debounce_bit`:
  - Ports: clock, reset, raw, stable, rise, fall.
  - Contains the synchronizer, counter and stable register.
  - Instantiated SW_W+1 times.
- The top combines per-channel rise/fall into `sw_changed` (OR of all switch channels, registered) and `step_pulse` (button channel's rise).

Test Plan (DEBOUNCE_CYCLES=4):
- Reset and power-up: hold reset=0 with sw_raw=4'b1010, then release → all outputs 0 during reset; sw_out=4'b1010 on the 6th rising edge after release; sw_changed high for exactly that one cycle.
- Glitch rejection: from a stable sw_out=4'b0000, pulse sw_raw[0]=1 for 3 cycles → sw_out stays 4'b0000 and sw_changed never asserts.
- Multi-bit change: sw_raw 4'b1010→4'b0101, held → sw_out=4'b0101 6 edges later, in a single cycle, with a single one-cycle sw_changed.
- Button bounce: btn_raw toggles 1,0,1,0,1 on successive cycles, then is held at 1 for 20 cycles and released → exactly one step_pulse, 6 edges after the final 0→1; no pulse on release.
- Async reset mid-count: sw_raw[3] changes, reset is asserted low after 3 edges (asynchronously, between edges) → sw_out and counters clear immediately without a clock; after release sw_out[3] updates only after a full fresh 6 edges.
- Channel independence: sw_raw[1] glitches repeatedly while sw_raw[2] is held high → sw_out[2] updates on schedule at 6 edges; sw_out[1] never changes.
